// File: rtl/mem_cache_unit_pkg.sv
// Shared definitions for the memory front-end.
//   - work_type encodings (size field and signed flag)
//   - sequencer FSM state encoding
//   - default IO region selector
//   - helpers: byte count from a size field, load-data extension
package mem_cache_unit_pkg;

    localparam int WORD_W = 32;

    // work_type[1:0] size field, work_type[WT_SIGNED] selects sign extension
    localparam logic [1:0] WT_BYTE   = 2'b00;
    localparam logic [1:0] WT_HALF   = 2'b01;
    localparam logic [1:0] WT_WORD   = 2'b10;
    localparam int         WT_SIGNED = 2;

    // addr[MEM_ADDR_W-1:MEM_ADDR_W-2] value that selects the IO region
    localparam logic [1:0] IO_SEL_DEF = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_XFER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] byte_count(input logic [1:0] sz);
        case (sz)
            WT_BYTE: return 3'd1;
            WT_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] extend_load(input logic [WORD_W-1:0] raw,
                                                      input logic [2:0]        wt);
        logic s;
        s = wt[WT_SIGNED];
        case (wt[1:0])
            WT_BYTE: return {{24{s & raw[7]}}, raw[7:0]};
            WT_HALF: return {{16{s & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_cache_unit_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset (clears valid bits)
//   i_rd_addr                word address for the combinational lookup
//   o_hit, o_rd_data         lookup result
//   i_fill_en/addr/data      line write (tag + data, sets valid)
//   i_inv_en/addr            snoop invalidate; clears the line only on tag match
// When fill and invalidate hit the same line in one cycle the invalidate wins.
module icache_dm
    import mem_cache_unit_pkg::*;
#(
    parameter int ICACHE_IDX_W = 4,
    parameter int MEM_ADDR_W   = 18
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [MEM_ADDR_W-1:2]   i_rd_addr,
    output logic                    o_hit,
    output logic [WORD_W-1:0]       o_rd_data,
    input  logic                    i_fill_en,
    input  logic [MEM_ADDR_W-1:2]   i_fill_addr,
    input  logic [WORD_W-1:0]       i_fill_data,
    input  logic                    i_inv_en,
    input  logic [MEM_ADDR_W-1:2]   i_inv_addr
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = MEM_ADDR_W - ICACHE_IDX_W - 2;

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [WORD_W-1:0]  r_data [LINES];

    logic [ICACHE_IDX_W-1:0] w_rd_idx, w_fill_idx, w_inv_idx;
    logic [TAG_W-1:0]        w_rd_tag, w_fill_tag, w_inv_tag;

    assign w_rd_idx   = i_rd_addr[ICACHE_IDX_W+1:2];
    assign w_rd_tag   = i_rd_addr[MEM_ADDR_W-1:ICACHE_IDX_W+2];
    assign w_fill_idx = i_fill_addr[ICACHE_IDX_W+1:2];
    assign w_fill_tag = i_fill_addr[MEM_ADDR_W-1:ICACHE_IDX_W+2];
    assign w_inv_idx  = i_inv_addr[ICACHE_IDX_W+1:2];
    assign w_inv_tag  = i_inv_addr[MEM_ADDR_W-1:ICACHE_IDX_W+2];

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_data = r_data[w_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else begin
            if (i_fill_en)
                r_valid[w_fill_idx] <= 1'b1;
            // Written after the fill so it takes precedence on the same line.
            if (i_inv_en && r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag))
                r_valid[w_inv_idx] <= 1'b0;
        end
    end

    // Tag/data arrays need no reset: a line is only trusted while valid.
    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= i_fill_data;
        end
    end

endmodule

// File: rtl/mem_cache_unit.sv
// Memory front-end: instruction cache, data/fetch arbiter and byte-serial
// RAM/IO sequencer on an 8-bit bus.
// Optional build macro: CACHE_FAIR_ARB_EN (alternating grant on contention;
// without it data requests have strict priority over fetch misses).
// Ports:
//   clk_in, rst_in, rdy_in          clock, sync active-high reset, global enable
//   mem_din/mem_dout/mem_a/mem_wr   external byte bus (read data has 1-cycle latency)
//   io_buffer_full                  UART back-pressure, stalls IO-region stores
//   rob_clear                       flush: blocks acceptance, aborts reads
//   need_inst/inst_addr/inst_*      fetch port
//   need_data/is_write/data_addr/data_in/work_type/data_*  load/store port
//   o_dbg_state                     current sequencer state
// Handshake: a request is held high until its *_handle pulses; *_handle is
// combinational in the accepting cycle. *_ready pulses exactly one cycle with
// the result (hits: handle and ready in the same cycle). rdy_in=0 forces all
// handle/ready low and freezes the sequencer.
module mem_cache_unit
    import mem_cache_unit_pkg::*;
#(
    parameter int         ICACHE_IDX_W = 4,
    parameter int         MEM_ADDR_W   = 18,
    parameter logic [1:0] IO_SEL_HI    = IO_SEL_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        rob_clear,
    input  logic        need_inst,
    input  logic [31:0] inst_addr,
    output logic        inst_handle,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    input  logic        need_data,
    input  logic        is_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic [2:0]  work_type,
    output logic        data_handle,
    output logic        data_ready,
    output logic [31:0] data_out,
    output logic [1:0]  o_dbg_state
);
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_buf;
    logic [2:0]  r_type, r_cnt, w_n;
    logic        r_is_write, r_is_inst;

    logic        w_hit, w_hit_serve, w_miss_req, w_can_accept;
    logic        w_grant_data, w_grant_inst, w_fill_ready, w_fill_en;
    logic        w_data_io, w_cur_io;
    logic [31:0] w_cache_data;

    assign w_n       = byte_count(r_type[1:0]);
    assign w_data_io = (data_addr[MEM_ADDR_W-1 -: 2] == IO_SEL_HI);
    assign w_cur_io  = (r_addr[MEM_ADDR_W-1 -: 2] == IO_SEL_HI);

    icache_dm #(.ICACHE_IDX_W(ICACHE_IDX_W), .MEM_ADDR_W(MEM_ADDR_W)) u_icache (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_rd_addr   (inst_addr[MEM_ADDR_W-1:2]),
        .o_hit       (w_hit),
        .o_rd_data   (w_cache_data),
        .i_fill_en   (w_fill_en),
        .i_fill_addr (r_addr[MEM_ADDR_W-1:2]),
        .i_fill_data (r_buf),
        .i_inv_en    (w_grant_data && is_write),
        .i_inv_addr  (data_addr[MEM_ADDR_W-1:2])
    );

    // Hits bypass the sequencer; they stand aside only while a fill is being
    // returned so the instruction port carries one result per cycle.
    assign w_hit_serve  = rdy_in && need_inst && w_hit && !rob_clear &&
                          !(r_state == S_DONE && r_is_inst);
    assign w_miss_req   = need_inst && !w_hit;
    assign w_can_accept = rdy_in && (r_state == S_IDLE) && !rob_clear;

`ifdef CACHE_FAIR_ARB_EN
    logic r_last_data;   // 1: data won the most recent contended grant
    logic w_contend;
    assign w_contend    = w_can_accept && need_data && w_miss_req;
    assign w_grant_data = w_can_accept && need_data && !(w_contend && r_last_data);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_last_data <= 1'b0;
        else if (w_contend)
            r_last_data <= w_grant_data;
    end
`else
    assign w_grant_data = w_can_accept && need_data;
`endif
    assign w_grant_inst = w_can_accept && w_miss_req && !w_grant_data;

    // IO-region reads must never be cached.
    assign w_fill_en = w_fill_ready && !w_cur_io;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else if (rdy_in)
            r_state <= w_next;
    end

    // Next-state logic. Reads run N+1 XFER cycles (address phase plus the
    // one-cycle RAM latency); writes run N.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_data)
                    w_next = (is_write && w_data_io && io_buffer_full) ? S_STALL : S_XFER;
                else if (w_grant_inst)
                    w_next = S_XFER;
            end
            S_STALL: if (!io_buffer_full) w_next = S_XFER;
            S_XFER: begin
                if (!r_is_write && rob_clear)
                    w_next = S_IDLE;
                else if (r_is_write ? (r_cnt == w_n - 3'd1) : (r_cnt == w_n))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_a        = 32'd0;
        mem_wr       = 1'b0;
        mem_dout     = 8'd0;
        data_ready   = 1'b0;
        w_fill_ready = 1'b0;
        case (r_state)
            S_XFER: begin
                if (r_cnt < w_n)
                    mem_a = r_addr + {29'd0, r_cnt};   // wraps modulo 2^32
                if (r_is_write) begin
                    mem_wr = 1'b1;
                    case (r_cnt[1:0])
                        2'd0:    mem_dout = r_wdata[7:0];
                        2'd1:    mem_dout = r_wdata[15:8];
                        2'd2:    mem_dout = r_wdata[23:16];
                        default: mem_dout = r_wdata[31:24];
                    endcase
                end
            end
            S_DONE: begin
                if (rdy_in && !rob_clear) begin
                    if (r_is_inst) w_fill_ready = 1'b1;
                    else           data_ready   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign inst_handle = w_grant_inst || w_hit_serve;
    assign inst_ready  = w_fill_ready || w_hit_serve;
    assign inst_out    = w_fill_ready ? r_buf : w_cache_data;
    assign data_handle = w_grant_data;
    assign data_out    = extend_load(r_buf, r_type);
    assign o_dbg_state = r_state;

    // Request latch, byte counter and read assembly. In XFER cycle k the bus
    // returns the byte addressed in cycle k-1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_type     <= 3'd0;
            r_cnt      <= 3'd0;
            r_is_write <= 1'b0;
            r_is_inst  <= 1'b0;
        end else if (rdy_in) begin
            if (w_grant_data) begin
                r_addr     <= data_addr;
                r_wdata    <= data_in;
                r_type     <= work_type;
                r_is_write <= is_write;
                r_is_inst  <= 1'b0;
                r_cnt      <= 3'd0;
            end else if (w_grant_inst) begin
                r_addr     <= inst_addr;
                r_type     <= {1'b0, WT_WORD};
                r_is_write <= 1'b0;
                r_is_inst  <= 1'b1;
                r_cnt      <= 3'd0;
            end else if (r_state == S_XFER) begin
                r_cnt <= r_cnt + 3'd1;
                if (!r_is_write) begin
                    case (r_cnt)
                        3'd1:    r_buf[7:0]   <= mem_din;
                        3'd2:    r_buf[15:8]  <= mem_din;
                        3'd3:    r_buf[23:16] <= mem_din;
                        3'd4:    r_buf[31:24] <= mem_din;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_cache_unit.sv
module tb_mem_cache_unit;
  import mem_cache_unit_pkg::*;

  logic        clk_in, rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full, rob_clear;
  logic        need_inst, inst_handle, inst_ready;
  logic [31:0] inst_addr, inst_out;
  logic        need_data, is_write, data_handle, data_ready;
  logic [31:0] data_addr, data_in, data_out;
  logic [2:0]  work_type;
  logic [1:0]  o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  mem_cache_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .rob_clear(rob_clear),
    .need_inst(need_inst), .inst_addr(inst_addr), .inst_handle(inst_handle),
    .inst_ready(inst_ready), .inst_out(inst_out),
    .need_data(need_data), .is_write(is_write), .data_addr(data_addr),
    .data_in(data_in), .work_type(work_type), .data_handle(data_handle),
    .data_ready(data_ready), .data_out(data_out), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // byte RAM: one-cycle read latency, preloaded while reset is held
  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    if (rst_in) begin
      ram[18'h00000] <= 8'h13; ram[18'h00001] <= 8'h05;
      ram[18'h00002] <= 8'h00; ram[18'h00003] <= 8'h00;
      ram[18'h00040] <= 8'h93; ram[18'h00041] <= 8'h00;
      ram[18'h00042] <= 8'h10; ram[18'h00043] <= 8'h00;
      ram[18'h01001] <= 8'hF0;
      ram[18'h02000] <= 8'h34; ram[18'h02001] <= 8'h92;
      ram[18'h3FFFF] <= 8'hAB;
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[17:0]];
  end

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic req_data(input bit wr, input logic [2:0] wt, input logic [31:0] a,
                          input logic [31:0] d);
    need_data = 1'b1;
    is_write  = wr;
    work_type = wt;
    data_addr = a;
    data_in   = d;
  endtask

  // Called at the start of cycle T+1; returns lat = k for a ready in cycle T+k.
  task automatic wait_ready(input bit want_inst, input int budget, output int lat,
                            output logic [31:0] val);
    lat = -1;
    val = 32'd0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk_in);
      if (want_inst ? inst_ready : data_ready) begin
        lat = k;
        val = want_inst ? inst_out : data_out;
        break;
      end
      @(posedge clk_in);
      #1;
    end
  endtask

  // Checks n write bytes against exp_q starting in cycle T+1, optional
  // rob_clear pulse in cycle T+clr_at, then data_ready at T+n+1.
  task automatic watch_store(input int n, input logic [31:0] base, input int clr_at);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      need_data = 1'b0;
      is_write  = 1'b0;
      rob_clear = (i + 1 == clr_at);
      @(negedge clk_in);
      chk("st_wr", {31'd0, mem_wr}, 32'd1);
      chk("st_addr", mem_a, base + i);
      chk("st_byte", {24'd0, mem_dout}, {24'd0, exp_q.pop_front()});
    end
    next_cycle();
    rob_clear = 1'b0;
    @(negedge clk_in);
    chk("st_ready", {31'd0, data_ready}, 32'd1);
  endtask

  int          lat, pulses;
  logic [31:0] val;
  bit          data_wins;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
    need_inst = 1'b0; inst_addr = 32'd0;
    need_data = 1'b0; is_write = 1'b0; data_addr = 32'd0; data_in = 32'd0; work_type = 3'd0;

    next_cycle();
    next_cycle();
    @(negedge clk_in);
    chk("rst_state", {30'd0, o_dbg_state}, {30'd0, S_IDLE});
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_hs", {28'd0, inst_handle, inst_ready, data_handle, data_ready}, 32'd0);
    chk("rst_dout32", data_out, 32'd0);
    next_cycle();
    rst_in = 1'b0;

    // fetch miss, then hit
    next_cycle();
    need_inst = 1'b1; inst_addr = 32'h0;
    @(negedge clk_in);
    chk("miss_handle", {31'd0, inst_handle}, 32'd1);
    chk("miss_rdy_T", {31'd0, inst_ready}, 32'd0);
    next_cycle();
    need_inst = 1'b0;
    wait_ready(1'b1, 12, lat, val);
    chk("miss_lat", lat, 32'd6);
    chk("miss_word", val, 32'h00000513);
    next_cycle();
    need_inst = 1'b1;
    @(negedge clk_in);
    chk("hit_handle", {31'd0, inst_handle}, 32'd1);
    chk("hit_ready", {31'd0, inst_ready}, 32'd1);
    chk("hit_word", inst_out, 32'h00000513);
    next_cycle();
    need_inst = 1'b0;
    @(negedge clk_in);
    chk("hit_idle", {30'd0, o_dbg_state}, {30'd0, S_IDLE});

    // loads: byte signed/unsigned, half signed, half unsigned across the wrap
    next_cycle();
    req_data(1'b0, 3'b100, 32'h1001, 32'd0);
    @(negedge clk_in);
    chk("lb_handle", {31'd0, data_handle}, 32'd1);
    next_cycle();
    need_data = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("lb_lat", lat, 32'd3);
    chk("lb_data", val, 32'hFFFFFFF0);

    next_cycle();
    req_data(1'b0, 3'b000, 32'h1001, 32'd0);
    next_cycle();
    need_data = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("lbu_lat", lat, 32'd3);
    chk("lbu_data", val, 32'h000000F0);

    next_cycle();
    req_data(1'b0, 3'b101, 32'h2000, 32'd0);
    next_cycle();
    need_data = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("lh_lat", lat, 32'd4);
    chk("lh_data", val, 32'hFFFF9234);

    next_cycle();
    req_data(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0);
    next_cycle();
    need_data = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("lhu_wrap", val, 32'h000013AB);

    // store word over the cached line, then the line must miss
    next_cycle();
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    req_data(1'b1, 3'b010, 32'h0, 32'hDEADBEEF);
    @(negedge clk_in);
    chk("sw_handle", {31'd0, data_handle}, 32'd1);
    watch_store(4, 32'h0, -1);
    next_cycle();
    need_inst = 1'b1; inst_addr = 32'h0;
    @(negedge clk_in);
    chk("snoop_miss", {31'd0, inst_ready}, 32'd0);
    chk("snoop_hs", {31'd0, inst_handle}, 32'd1);
    next_cycle();
    need_inst = 1'b0;
    wait_ready(1'b1, 12, lat, val);
    chk("refill_lat", lat, 32'd6);
    chk("refill_word", val, 32'hDEADBEEF);

    // rob_clear masks a hit
    next_cycle();
    need_inst = 1'b1; rob_clear = 1'b1;
    @(negedge clk_in);
    chk("clr_hit_rdy", {31'd0, inst_ready}, 32'd0);
    chk("clr_hit_hs", {31'd0, inst_handle}, 32'd0);
    next_cycle();
    rob_clear = 1'b0;
    @(negedge clk_in);
    chk("hit2_word", inst_out, 32'hDEADBEEF);
    chk("hit2_ready", {31'd0, inst_ready}, 32'd1);
    next_cycle();
    need_inst = 1'b0;

    // IO store under back-pressure for 3 cycles
    io_buffer_full = 1'b1;
    req_data(1'b1, 3'b000, 32'h30000, 32'h0000005A);
    @(negedge clk_in);
    chk("io_handle", {31'd0, data_handle}, 32'd1);
    next_cycle();
    need_data = 1'b0; is_write = 1'b0;
    @(negedge clk_in);
    chk("io_stall_st", {30'd0, o_dbg_state}, {30'd0, S_STALL});
    chk("io_wr_t1", {31'd0, mem_wr}, 32'd0);
    next_cycle();
    @(negedge clk_in);
    chk("io_wr_t2", {31'd0, mem_wr}, 32'd0);
    next_cycle();
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_wr_t3", {31'd0, mem_wr}, 32'd0);
    next_cycle();
    @(negedge clk_in);
    chk("io_wr_t4", {31'd0, mem_wr}, 32'd1);
    chk("io_byte", {24'd0, mem_dout}, 32'h5A);
    chk("io_addr", mem_a, 32'h30000);
    next_cycle();
    @(negedge clk_in);
    chk("io_ready", {31'd0, data_ready}, 32'd1);

    // rob_clear aborts a word load at T+2
    next_cycle();
    req_data(1'b0, 3'b010, 32'h2000, 32'd0);
    next_cycle();
    need_data = 1'b0;
    next_cycle();
    rob_clear = 1'b1;
    @(negedge clk_in);
    chk("abort_rdy", {31'd0, data_ready}, 32'd0);
    next_cycle();
    rob_clear = 1'b0;
    @(negedge clk_in);
    chk("abort_idle", {30'd0, o_dbg_state}, {30'd0, S_IDLE});
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk_in);
      if (data_ready) pulses++;
    end
    chk("abort_pulses", pulses, 32'd0);

    // rob_clear mid-store: all bytes still written
    next_cycle();
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    req_data(1'b1, 3'b010, 32'h3000, 32'h11223344);
    watch_store(4, 32'h3000, 2);
    next_cycle();
    req_data(1'b0, 3'b010, 32'h3000, 32'd0);
    next_cycle();
    need_data = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("lw_lat", lat, 32'd6);
    chk("lw_after_clr", val, 32'h11223344);

    // contention: data request and fetch miss together, twice
    for (int r = 0; r < 2; r++) begin
`ifdef CACHE_FAIR_ARB_EN
      data_wins = (r == 0);
`else
      data_wins = 1'b1;
`endif
      next_cycle();
      need_inst = 1'b1; inst_addr = 32'h40;
      req_data(1'b0, 3'b000, 32'h1001, 32'd0);
      @(negedge clk_in);
      chk("arb_dhs", {31'd0, data_handle}, {31'd0, data_wins});
      chk("arb_ihs", {31'd0, inst_handle}, {31'd0, !data_wins});
      next_cycle();
      need_inst = 1'b0; need_data = 1'b0;
      wait_ready(!data_wins, 12, lat, val);
      chk("arb_val", val, data_wins ? 32'h000000F0 : 32'h00100093);
    end

    // rdy_in low freezes the bus and masks ready
    next_cycle();
    req_data(1'b0, 3'b000, 32'h1001, 32'd0);
    next_cycle();
    need_data = 1'b0; rdy_in = 1'b0;
    need_inst = 1'b1; inst_addr = 32'h0;
    @(negedge clk_in);
    chk("frz_hit", {31'd0, inst_ready}, 32'd0);
    chk("frz_a1", mem_a, 32'h1001);
    next_cycle();
    @(negedge clk_in);
    chk("frz_a2", mem_a, 32'h1001);
    next_cycle();
    rdy_in = 1'b1; need_inst = 1'b0;
    wait_ready(1'b0, 12, lat, val);
    chk("frz_lat", lat, 32'd3);
    chk("frz_data", val, 32'h000000F0);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_cache_unit.md
Name: mem_cache_unit

Overview:
- Next-generation memory front-end: a parametrised direct-mapped instruction cache, a data/instruction arbiter and the byte-serial RAM/IO sequencer, all in one block.
- Sits between the fetcher/LSB and the external 8-bit memory bus.
- Adds over the previous generation: a configurable cache depth, store-snoop invalidation, an IO back-pressure stall, and speculative-read abort without losing stores.

Parameters:
ICACHE_IDX_W, 4, log2 of the number of one-word cache lines (16 lines by default).
MEM_ADDR_W, 18, number of significant address bits; tag = addr[MEM_ADDR_W-1:ICACHE_IDX_W+2].
IO_SEL_HI, 2'b11, value of addr[MEM_ADDR_W-1:MEM_ADDR_W-2] that selects the IO region.

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low all state holds and no outputs change
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full
rob_clear  in  1  pipeline flush
need_inst  in  1  fetch request
inst_addr  in  32  fetch address (word aligned)
inst_handle  out  1  fetch accepted this cycle
inst_ready  out  1  instruction valid this cycle
inst_out  out  32  instruction word
need_data  in  1  load/store request
is_write  in  1  1 = store
data_addr  in  32  load/store address
data_in  in  32  store data
work_type  in  3  [2] signed, [1:0] 00 byte / 01 half / 10 word
data_handle  out  1  data request accepted this cycle
data_ready  out  1  load data valid / store done this cycle
data_out  out  32  extended load data

Behaviour:
- Reset: FSM=IDLE, all valid bits cleared, mem_wr=0, mem_a=0, mem_dout=0, all handle/ready outputs 0, data_out=0.
- FSM states: IDLE, STALL, XFER, DONE.
- Byte count N = 1/2/4 from work_type[1:0]. Fetches always use N=4, unsigned.
- Cache hit (valid and tag match, need_inst=1, rob_clear=0):
  - inst_handle=1 and inst_ready=1 combinationally in the same cycle, with inst_out = cached word.
  - A hit never occupies the sequencer.
- Acceptance, cycle T (FSM in IDLE, rob_clear=0):
  - need_data pending → data_handle=1; this wins over a fetch miss.
  - Otherwise a fetch miss → inst_handle=1.
  - Address, type, write flag and data are latched.
- Read timing: mem_a = addr+i in cycle T+1+i; byte i is sampled at T+2+i; ready pulses for one cycle at T+N+2.
- Write timing: mem_wr=1 and mem_dout = byte i (little-endian) in cycle T+1+i; data_ready pulses at T+N+1.
- Whenever not transferring: mem_wr=0.
- IO stall:
  - A store to the IO region while io_buffer_full=1 goes to STALL, with mem_wr=0.
  - It issues on the first cycle io_buffer_full=0; all timing shifts by the stall length.
  - IO reads are never cached.
- Load extension: signed → sign-extend from bit 8N-1; unsigned → zero-extend.
- Cache fill: a completed fetch miss writes the line and sets valid in the DONE cycle.
- Snoop:
  - A store whose word address matches a valid line clears that line's valid bit at acceptance.
  - A fill and a snoop to the same index in the same cycle: the snoop wins (line invalid).
- rob_clear=1:
  - No acceptance, and inst_ready=0 even on a hit.
  - An in-flight read aborts: FSM returns to IDLE next cycle, with no ready and no fill.
  - An in-flight store completes all bytes; its data_ready is suppressed only if DONE coincides with rob_clear.
- rdy_in=0: freezes FSM, counters and bus outputs; handle/ready are forced to 0.
- Address wrap: byte addresses increment modulo 2^32. Unaligned accesses are handled bytewise with no fault.

Optional Feature:
- Macro: CACHE_FAIR_ARB_EN.
- Defined: when both a data request and a fetch miss are pending in IDLE, grant alternates; the requester that did not win the last contended grant wins.
- Undefined: data has strict priority (fetch can starve).
- Hit timing is unaffected in both cases.

Decomposition:
- Shared package/header (Config.v):
  - work_type encodings (WT_BYTE, WT_HALF, WT_WORD, WT_SIGNED);
  - FSM state encodings;
  - IO region select constant.
- Sub-module icache_dm, parameterised by ICACHE_IDX_W and MEM_ADDR_W: tag/valid/data arrays, combinational hit/read port, fill port and invalidate port.

Test Plan:
- Reset, fetch 0x0000 miss with RAM bytes 13 05 00 00 → inst_handle at T, inst_ready at T+6 with inst_out=0x00000513; re-fetch 0x0000 → hit, inst_ready in the same cycle.
- Load byte, signed, at 0x1001 holding 0xF0 → data_out=0xFFFFFFF0 at T+3; unsigned → 0x000000F0.
- Store word 0xDEADBEEF to 0x0000 after caching it → mem_dout sequence EF BE AD DE, data_ready at T+5; next fetch 0x0000 misses.
- Store byte to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write; data_ready 3 cycles late.
- rob_clear at T+2 of a word load → no data_ready, FSM IDLE at T+3; rob_clear mid-store → all 4 bytes still written.
- Simultaneous need_data and fetch miss twice → default: data granted both times; with CACHE_FAIR_ARB_EN: data, then inst.
